jtkcpu_busclk: RTL and testbench

- Parametrised bus-cycle clock-enable generator for the JTKCPU family. It generalises the fixed two-phase cen/cen2 split into N phases.
- Adds programmable wait states, DTACK stall with timeout, and a HALT/bus-grant handshake.
- Sits between the system cen source and the CPU core. It feeds cen to ctrl/alu/regs/idx and cen2 to memctrl/regs.

---
 rtl/jtkcpu_busclk.sv | 147 ++++++++++++++
 tb/tb_jtkcpu_busclk.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_busclk.sv
// rtl/jtkcpu_busclk.sv - N-phase bus-cycle clock-enable generator with wait states, DTACK timeout and halt handshake.
// Optional stall statistics counter: define JTKCPU_BUSCLK_STATS_EN.
module jtkcpu_busclk #(
  parameter int PHASES = 2,
  parameter int WAITW  = 3,
  parameter int TOUTW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen2,
  input  logic              dtack,
  input  logic              halt,
  input  logic [WAITW-1:0]  wait_cfg,
`ifdef JTKCPU_BUSCLK_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       stall_cnt,
`endif
  output logic              cen_out,
  output logic [PHASES-1:0] cen_ph,
  output logic              cen,
  output logic              as,
  output logic              bus_ack,
  output logic              timeout
);

  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_HALT
  } state_t;

  state_t            st, st_nxt;
  logic [PW-1:0]     ph, ph_nxt;
  logic [WAITW-1:0]  wcnt, wcnt_nxt;
  logic [TOUTW-1:0]  tcnt, tcnt_nxt;
  logic [PHASES-1:0] pulse;
  logic              out_nxt, tout_nxt, as_nxt, ack_nxt;
  logic              tout_hit, adv;

  assign tout_hit = &tcnt;
  assign adv      = cen2 && (st == ST_RUN) && (dtack || tout_hit);

  always_comb begin
    st_nxt   = st;
    ph_nxt   = ph;
    wcnt_nxt = wcnt;
    tcnt_nxt = tcnt;
    pulse    = '0;
    out_nxt  = 1'b0;
    tout_nxt = 1'b0;
    case (st)
      ST_RUN: begin
        if (adv) begin
          tcnt_nxt = '0;
          // A new cycle never starts while halt is requested.
          if ((ph == '0) && halt) begin
            st_nxt = ST_HALT;
          end else begin
            out_nxt  = 1'b1;
            pulse    = PHASES'(1) << ph;
            tout_nxt = ~dtack;
            if (ph == PH_LAST) begin
              ph_nxt = '0;
              if (halt) begin
                st_nxt = ST_HALT;
              end else if (wait_cfg != '0) begin
                st_nxt   = ST_WAIT;
                wcnt_nxt = wait_cfg;
              end
            end else begin
              ph_nxt = ph + 1'b1;
            end
          end
        end else if (cen2) begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cen2) begin
          if (wcnt <= WAITW'(1)) begin
            st_nxt   = ST_RUN;
            wcnt_nxt = '0;
          end else begin
            wcnt_nxt = wcnt - 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (!halt) begin
          st_nxt = ST_RUN;
          ph_nxt = '0;
        end
      end
      default: begin
        st_nxt = ST_RUN;
        ph_nxt = '0;
      end
    endcase
    as_nxt  = (st_nxt == ST_RUN) && (ph_nxt != '0);
    ack_nxt = (st_nxt == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_RUN;
      ph      <= '0;
      wcnt    <= '0;
      tcnt    <= '0;
      cen_out <= 1'b0;
      cen_ph  <= '0;
      as      <= 1'b0;
      bus_ack <= 1'b0;
      timeout <= 1'b0;
    end else begin
      st      <= st_nxt;
      ph      <= ph_nxt;
      wcnt    <= wcnt_nxt;
      tcnt    <= tcnt_nxt;
      cen_out <= out_nxt;
      cen_ph  <= pulse;
      as      <= as_nxt;
      bus_ack <= ack_nxt;
      timeout <= tout_nxt;
    end
  end

  assign cen = cen_ph[PHASES-1];

`ifdef JTKCPU_BUSCLK_STATS_EN
  logic stall_evt;
  assign stall_evt = (st != ST_RUN) || (cen2 && !dtack && !tout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtkcpu_busclk.sv
// tb/tb_jtkcpu_busclk.sv - directed self-checking bench for jtkcpu_busclk (two-phase and four-phase instances).
module tb_jtkcpu_busclk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen2 = 1'b0, dtack = 1'b1, halt = 1'b0;
  logic [2:0] wcfg_a = '0, wcfg_b = '0;
  logic stats_clr = 1'b0;

  logic       a_cen_out, a_cen, a_as, a_bus_ack, a_timeout;
  logic [1:0] a_cen_ph;
  logic       b_cen_out, b_cen, b_as, b_bus_ack, b_timeout;
  logic [3:0] b_cen_ph;
  logic [15:0] a_stall_cnt, b_stall_cnt;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  jtkcpu_busclk #(.PHASES(2), .WAITW(3), .TOUTW(3)) u_a (
    .clk(clk), .rst_n(rst_n), .cen2(cen2), .dtack(dtack), .halt(halt), .wait_cfg(wcfg_a),
`ifdef JTKCPU_BUSCLK_STATS_EN
    .stats_clr(stats_clr), .stall_cnt(a_stall_cnt),
`endif
    .cen_out(a_cen_out), .cen_ph(a_cen_ph), .cen(a_cen), .as(a_as),
    .bus_ack(a_bus_ack), .timeout(a_timeout)
  );

  jtkcpu_busclk #(.PHASES(4), .WAITW(3), .TOUTW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .cen2(cen2), .dtack(dtack), .halt(halt), .wait_cfg(wcfg_b),
`ifdef JTKCPU_BUSCLK_STATS_EN
    .stats_clr(stats_clr), .stall_cnt(b_stall_cnt),
`endif
    .cen_out(b_cen_out), .cen_ph(b_cen_ph), .cen(b_cen), .as(b_as),
    .bus_ack(b_bus_ack), .timeout(b_timeout)
  );

  task automatic tick(input logic c);
    cen2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; cen2 = 1'b0; dtack = 1'b1; halt = 1'b0; wcfg_a = '0; wcfg_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    vec++;
    if ({a_cen_out, a_cen_ph, a_cen, a_as, a_bus_ack, a_timeout} !== 7'b0) begin
      errs++; $display("FAIL reset_a got %b want 0", {a_cen_out, a_cen_ph, a_cen, a_as, a_bus_ack, a_timeout});
    end
    vec++;
    if ({b_cen_out, b_cen_ph, b_cen, b_as, b_bus_ack, b_timeout} !== 9'b0) begin
      errs++; $display("FAIL reset_b got %b want 0", {b_cen_out, b_cen_ph, b_cen, b_as, b_bus_ack, b_timeout});
    end
  endtask

  task automatic test_legacy;
    int n = 0, n_out = 0, n_cen = 0;
    logic c;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      c = (i % 3 == 0);
      if (c) n++;
      tick(c);
      n_out += a_cen_out;
      n_cen += a_cen;
      vec++;
      if (a_cen_out !== c) begin
        errs++; $display("FAIL legacy_cen_out i=%0d got %b want %b", i, a_cen_out, c);
      end
      vec++;
      if (a_cen_ph !== {c && (n % 2 == 0), c && (n % 2 == 1)}) begin
        errs++; $display("FAIL legacy_cen_ph i=%0d got %b want %b", i, a_cen_ph, {c && (n % 2 == 0), c && (n % 2 == 1)});
      end
      vec++;
      if (a_as !== (n % 2 == 1)) begin
        errs++; $display("FAIL legacy_as i=%0d got %b want %b", i, a_as, (n % 2 == 1));
      end
    end
    vec++;
    if (n_out != 12 || n_cen != 6) begin
      errs++; $display("FAIL legacy_counts got out=%0d cen=%0d want out=12 cen=6", n_out, n_cen);
    end
  endtask

  task automatic test_wait_states;
    int pos;
    do_reset();
    wcfg_b = 3'd3;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1);
      pos = (i - 1) % 7;
      vec++;
      if (b_cen !== (pos == 3)) begin
        errs++; $display("FAIL wait_cen clk=%0d got %b want %b", i, b_cen, (pos == 3));
      end
      vec++;
      if (b_cen_out !== (pos < 4)) begin
        errs++; $display("FAIL wait_cen_out clk=%0d got %b want %b", i, b_cen_out, (pos < 4));
      end
      vec++;
      if (b_as !== (pos < 3)) begin
        errs++; $display("FAIL wait_as clk=%0d got %b want %b", i, b_as, (pos < 3));
      end
    end
  endtask

  task automatic test_dtack_stall;
    do_reset();
    tick(1'b1);
    dtack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1);
      vec++;
      if ({a_cen_out, a_cen_ph, a_as} !== 4'b0001) begin
        errs++; $display("FAIL stall_hold k=%0d got %b want 0001", k, {a_cen_out, a_cen_ph, a_as});
      end
    end
    dtack = 1'b1;
    tick(1'b1);
    vec++;
    if ({a_cen, a_timeout, a_as} !== 3'b100) begin
      errs++; $display("FAIL stall_release got %b want 100", {a_cen, a_timeout, a_as});
    end
  endtask

  task automatic test_timeout;
    do_reset();
    tick(1'b1);
    dtack = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1'b1);
      vec++;
      if ({a_cen, a_timeout} !== 2'b00) begin
        errs++; $display("FAIL tout_early k=%0d got %b want 00", k, {a_cen, a_timeout});
      end
    end
    tick(1'b1);
    vec++;
    if ({a_cen_out, a_cen, a_timeout} !== 3'b111) begin
      errs++; $display("FAIL tout_forced got %b want 111", {a_cen_out, a_cen, a_timeout});
    end
    vec++;
    if (b_timeout !== 1'b0) begin
      errs++; $display("FAIL tout_wide got %b want 0", b_timeout);
    end
    tick(1'b1);
    vec++;
    if ({a_cen_out, a_timeout} !== 2'b00) begin
      errs++; $display("FAIL tout_tcnt_clear got %b want 00", {a_cen_out, a_timeout});
    end
    dtack = 1'b1;
  endtask

  task automatic test_halt;
    do_reset();
    tick(1'b1);
    halt = 1'b1;
    tick(1'b1);
    vec++;
    if ({a_cen, a_bus_ack} !== 2'b11) begin
      errs++; $display("FAIL halt_finish got %b want 11", {a_cen, a_bus_ack});
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b1);
      vec++;
      if ({a_cen_out, a_cen_ph, a_as, a_bus_ack} !== 5'b00001) begin
        errs++; $display("FAIL halt_idle k=%0d got %b want 00001", k, {a_cen_out, a_cen_ph, a_as, a_bus_ack});
      end
    end
    halt = 1'b0;
    tick(1'b0);
    vec++;
    if (a_bus_ack !== 1'b0) begin
      errs++; $display("FAIL halt_release got %b want 0", a_bus_ack);
    end
    tick(1'b1);
    vec++;
    if ({a_cen_out, a_cen_ph} !== 3'b101) begin
      errs++; $display("FAIL halt_resume got %b want 101", {a_cen_out, a_cen_ph});
    end
    tick(1'b1);
    halt = 1'b1;
    tick(1'b1);
    vec++;
    if ({a_cen_out, a_cen_ph, a_bus_ack} !== 4'b0001) begin
      errs++; $display("FAIL halt_ph0 got %b want 0001", {a_cen_out, a_cen_ph, a_bus_ack});
    end
    halt = 1'b0;
    tick(1'b1);
    vec++;
    if ({a_cen_out, a_bus_ack} !== 2'b00) begin
      errs++; $display("FAIL halt_ph0_release got %b want 00", {a_cen_out, a_bus_ack});
    end
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    wcfg_b = 3'd3;
    for (int k = 0; k < 5; k++) tick(1'b1);
    vec++;
    if ({a_cen_out, a_cen_ph, a_as} !== 4'b1011) begin
      errs++; $display("FAIL pre_reset got %b want 1011", {a_cen_out, a_cen_ph, a_as});
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({a_cen_out, a_cen_ph, a_as, b_cen_out, b_cen_ph, b_as, a_bus_ack, b_bus_ack} !== 12'b0) begin
      errs++; $display("FAIL async_reset got %b want 0", {a_cen_out, a_cen_ph, a_as, b_cen_out, b_cen_ph, b_as, a_bus_ack, b_bus_ack});
    end
`ifdef JTKCPU_BUSCLK_STATS_EN
    vec++;
    if (b_stall_cnt !== 16'd0) begin
      errs++; $display("FAIL stats_reset got %0d want 0", b_stall_cnt);
    end
`endif
    cen2 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1);
    vec++;
    if ({a_cen_ph, b_cen_ph} !== 6'b01_0001) begin
      errs++; $display("FAIL post_reset got %b want 010001", {a_cen_ph, b_cen_ph});
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_wait_states();
    test_dtack_stall();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
